// File: rtl/aqua_pkg.sv
// Shared state encodings and level-class codes for the multi-tank controller.
package aqua_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL      = 4'd0,
        ST_ZERA_VLV     = 4'd1,
        ST_INICIO_CICLO = 4'd2,
        ST_PREPARACAO   = 4'd3,
        ST_MEDIR        = 4'd4,
        ST_ANALISA      = 4'd5,
        ST_DECIDE       = 4'd6,
        ST_ABRE         = 4'd7,
        ST_FECHA        = 4'd8,
        ST_ESPERA       = 4'd9,
        ST_ENVIA        = 4'd10,
        ST_MUDA         = 4'd11,
        ST_PROX_CANAL   = 4'd12,
        ST_FIM_CICLO    = 4'd13
    } estado_t;

    localparam logic [1:0] CLS_NORMAL = 2'b00;
    localparam logic [1:0] CLS_BAIXA  = 2'b01;
    localparam logic [1:0] CLS_ALTA   = 2'b10;
    localparam logic [1:0] CLS_M_ALTA = 2'b11;

    // Upper thresholds are inclusive, the low threshold is exclusive.
    function automatic logic [1:0] classifica(input int unsigned m,
                                              input int unsigned lb,
                                              input int unsigned la,
                                              input int unsigned lma);
        if (m >= lma)
            return CLS_M_ALTA;
        else if (m >= la)
            return CLS_ALTA;
        else if (m < lb)
            return CLS_BAIXA;
        else
            return CLS_NORMAL;
    endfunction

endpackage

// File: rtl/aqua_contador_espera.sv
// Settle-time counter: cleared by zera, advances while conta, fim at CICLOS-1.
module aqua_contador_espera #(
    parameter int CICLOS = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = (CICLOS > 1) ? $clog2(CICLOS) : 1;

    logic [W-1:0] contagem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            contagem <= '0;
        else if (zera)
            contagem <= '0;
        else if (conta)
            contagem <= contagem + 1'b1;
    end

    assign fim = (contagem == W'(CICLOS - 1));

endmodule

// File: rtl/aqua_multi_uc.sv
// Round-robin tank controller: measure, classify, drive valve/buzzers, settle, report.
// Optional valve-close hysteresis enabled by defining AQUA_HISTERESE_EN.
//
// state        | meaning
// INICIAL      | idle after reset, waits for iniciar
// ZERA_VLV     | clear all valves and buzzers
// INICIO_CICLO | waits for iniciar to start a sweep
// PREPARACAO   | zera pulse for the front-end
// MEDIR        | request sample from current tank
// ANALISA      | classify sample, update tank buzzers
// DECIDE       | choose valve action
// ABRE / FECHA | move current tank valve
// ESPERA       | settle after valve move
// ENVIA / MUDA | send report character / advance character
// PROX_CANAL   | select next tank
// FIM_CICLO    | pronto pulse, sweep done
module aqua_multi_uc
    import aqua_pkg::*;
#(
    parameter int N_CANAIS      = 4,
    parameter int LARG_MEDIDA   = 12,
    parameter int LIMIAR_BAIXO  = 400,
    parameter int LIMIAR_ALTO   = 2400,
    parameter int LIMIAR_M_ALTO = 3200,
    parameter int CICLOS_ESPERA = 50_000_000,
    parameter int HISTERESE     = 128
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        iniciar,
    input  logic [LARG_MEDIDA-1:0]      medida,
    input  logic                        fim_medida,
    input  logic                        descartar_medida,
    input  logic                        fim_caracter,
    input  logic                        fim_mensagem,
    output logic [$clog2(N_CANAIS)-1:0] canal,
    output logic                        zera,
    output logic                        mensurar_nvl,
    output logic [1:0]                  classificacao,
    output logic [N_CANAIS-1:0]         valvulas,
    output logic [N_CANAIS-1:0]         buzzer_baixa,
    output logic [N_CANAIS-1:0]         buzzer_alta,
    output logic                        envia,
    output logic                        muda,
    output logic                        pronto,
    output logic [3:0]                  db_estado
);

    localparam int LC = $clog2(N_CANAIS);

    estado_t    estado, estado_prox;
    logic       fim_espera;
    logic       close_ok;
    logic       valv_atual;
    logic [1:0] cls_medida;

    assign valv_atual = valvulas[canal];
    assign cls_medida = classifica(32'(medida), LIMIAR_BAIXO, LIMIAR_ALTO, LIMIAR_M_ALTO);
    assign db_estado  = estado;

`ifdef AQUA_HISTERESE_EN
    localparam int LIMIAR_FECHA = LIMIAR_M_ALTO - HISTERESE;

    logic [LARG_MEDIDA-1:0] medida_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            medida_reg <= '0;
        else if (estado == ST_ANALISA)
            medida_reg <= medida;
    end

    assign close_ok = (int'(medida_reg) < LIMIAR_FECHA);
`else
    assign close_ok = 1'b1;
`endif

    aqua_contador_espera #(
        .CICLOS (CICLOS_ESPERA)
    ) u_espera (
        .clock (clock),
        .reset (reset),
        .zera  ((estado == ST_ABRE) || (estado == ST_FECHA)),
        .conta (estado == ST_ESPERA),
        .fim   (fim_espera)
    );

    always_comb begin
        estado_prox = estado;
        case (estado)
            ST_INICIAL:      if (iniciar) estado_prox = ST_ZERA_VLV;
            ST_ZERA_VLV:     estado_prox = ST_INICIO_CICLO;
            ST_INICIO_CICLO: if (iniciar) estado_prox = ST_PREPARACAO;
            ST_PREPARACAO:   estado_prox = ST_MEDIR;
            ST_MEDIR:
                if (fim_medida)
                    estado_prox = descartar_medida ? ST_PROX_CANAL : ST_ANALISA;
            ST_ANALISA:      estado_prox = ST_DECIDE;
            ST_DECIDE:
                if (classificacao == CLS_M_ALTA && !valv_atual)
                    estado_prox = ST_ABRE;
                else if (classificacao != CLS_M_ALTA && valv_atual && close_ok)
                    estado_prox = ST_FECHA;
                else
                    estado_prox = ST_ENVIA;
            ST_ABRE:         estado_prox = ST_ESPERA;
            ST_FECHA:        estado_prox = ST_ESPERA;
            ST_ESPERA:       if (fim_espera) estado_prox = ST_ENVIA;
            ST_ENVIA:
                if (fim_caracter)
                    estado_prox = fim_mensagem ? ST_PROX_CANAL : ST_MUDA;
            ST_MUDA:         estado_prox = ST_ENVIA;
            ST_PROX_CANAL:
                estado_prox = (canal == LC'(N_CANAIS - 1)) ? ST_FIM_CICLO : ST_PREPARACAO;
            ST_FIM_CICLO:    estado_prox = ST_INICIO_CICLO;
            default:         estado_prox = ST_INICIAL;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= ST_INICIAL;
            canal         <= '0;
            classificacao <= CLS_NORMAL;
            valvulas      <= '0;
            buzzer_baixa  <= '0;
            buzzer_alta   <= '0;
            zera          <= 1'b0;
            mensurar_nvl  <= 1'b0;
            envia         <= 1'b0;
            muda          <= 1'b0;
            pronto        <= 1'b0;
        end else begin
            estado       <= estado_prox;
            zera         <= (estado_prox == ST_PREPARACAO);
            mensurar_nvl <= (estado_prox == ST_MEDIR);
            envia        <= (estado_prox == ST_ENVIA);
            muda         <= (estado_prox == ST_MUDA);
            pronto       <= (estado_prox == ST_FIM_CICLO);

            case (estado)
                ST_ZERA_VLV: begin
                    valvulas     <= '0;
                    buzzer_baixa <= '0;
                    buzzer_alta  <= '0;
                end
                ST_ANALISA: begin
                    classificacao       <= cls_medida;
                    buzzer_baixa[canal] <= (cls_medida == CLS_BAIXA);
                    buzzer_alta[canal]  <= cls_medida[1];
                end
                ST_ABRE:  valvulas[canal] <= 1'b1;
                ST_FECHA: valvulas[canal] <= 1'b0;
                ST_PROX_CANAL:
                    canal <= (canal == LC'(N_CANAIS - 1)) ? '0 : canal + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aqua_multi_uc.sv
// Scoreboard bench for aqua_multi_uc: randomized sweeps against a tank-level reference model.
module tb_aqua_multi_uc;

    localparam int N = 4;
    localparam int C = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        iniciar = 1'b0;
    logic [11:0] medida = '0;
    logic        fim_medida = 1'b0;
    logic        descartar_medida = 1'b0;
    logic        fim_caracter = 1'b0;
    logic        fim_mensagem = 1'b0;
    logic [1:0]  canal;
    logic        zera, mensurar_nvl, envia, muda, pronto;
    logic [1:0]  classificacao;
    logic [3:0]  valvulas, buzzer_baixa, buzzer_alta, db_estado;

    aqua_multi_uc #(
        .N_CANAIS      (N),
        .CICLOS_ESPERA (C)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .iniciar          (iniciar),
        .medida           (medida),
        .fim_medida       (fim_medida),
        .descartar_medida (descartar_medida),
        .fim_caracter     (fim_caracter),
        .fim_mensagem     (fim_mensagem),
        .canal            (canal),
        .zera             (zera),
        .mensurar_nvl     (mensurar_nvl),
        .classificacao    (classificacao),
        .valvulas         (valvulas),
        .buzzer_baixa     (buzzer_baixa),
        .buzzer_alta      (buzzer_alta),
        .envia            (envia),
        .muda             (muda),
        .pronto           (pronto),
        .db_estado        (db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         canal;
        logic [1:0] cls;
        logic [3:0] v, bb, ba;
        int         lat;
    } msg_t;

    typedef struct {
        int         mudas;
        int         zeras;
        logic [3:0] v;
        logic [1:0] cls;
    } swp_t;

    msg_t msg_q[$];
    swp_t swp_q[$];

    // Reference model state: per-tank valves/buzzers and the last class.
    logic [3:0] m_v = '0, m_bb = '0, m_ba = '0;
    logic [1:0] m_cls = '0;

    int tab_m[4];
    bit tab_d[4];
    int tab_n[4];
    int pts[10] = '{399, 400, 2399, 2400, 3071, 3072, 3199, 3200, 0, 4095};

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nome, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_cls(input int m);
        if (m >= 3200) return 2'd3;
        if (m >= 2400) return 2'd2;
        if (m < 400)   return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit fecha_ok(input int m);
`ifdef AQUA_HISTERESE_EN
        return (m < 3200 - 128);
`else
        return (m >= 0);
`endif
    endfunction

    function automatic int pick();
        if ($urandom_range(0, 1) == 0)
            return pts[$urandom_range(0, 9)];
        return int'($urandom_range(0, 4095));
    endfunction

    function automatic logic sinal(input int which);
        case (which)
            0:       return mensurar_nvl;
            1:       return envia;
            default: return pronto;
        endcase
    endfunction

    task automatic timeout(input string nome);
        checks++;
        errors++;
        $display("FAIL %s: timed out, required within 400 cycles", nome);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic espera(input int which, input string nome);
        int n = 0;
        while (!sinal(which)) begin
            @(negedge clock);
            n++;
            if (n > 400) timeout(nome);
        end
    endtask

    task automatic servir(input int k, input int m, input bit d, input int nch);
        logic [1:0] c;
        bit mov;
        msg_t e;
        espera(0, "wait_mensurar");
        repeat ($urandom_range(0, 2)) @(negedge clock);
        medida = 12'(m);
        descartar_medida = d;
        fim_medida = 1'b1;
        if (!d) begin
            c = ref_cls(m);
            m_cls = c;
            m_bb[k] = (c == 2'd1);
            m_ba[k] = (c >= 2'd2);
            mov = 1'b0;
            if (c == 2'd3 && !m_v[k]) begin
                m_v[k] = 1'b1;
                mov = 1'b1;
            end else if (c != 2'd3 && m_v[k] && fecha_ok(m)) begin
                m_v[k] = 1'b0;
                mov = 1'b1;
            end
            e.canal = k; e.cls = c; e.v = m_v; e.bb = m_bb; e.ba = m_ba;
            e.lat = mov ? 4 + C : 3;
            msg_q.push_back(e);
        end
        @(negedge clock);
        fim_medida = 1'b0;
        descartar_medida = 1'b0;
        if (!d) begin
            for (int i = 0; i < nch; i++) begin
                espera(1, "wait_envia");
                repeat ($urandom_range(0, 2)) @(negedge clock);
                fim_caracter = 1'b1;
                fim_mensagem = (i == nch - 1);
                @(negedge clock);
                fim_caracter = 1'b0;
                fim_mensagem = 1'b0;
            end
        end
    endtask

    task automatic iniciar_pulso(input bit primeira);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        if (primeira) begin
            repeat (2) @(negedge clock);
            iniciar = 1'b1;
            @(negedge clock);
            iniciar = 1'b0;
        end
    endtask

    task automatic varredura(input bit primeira);
        swp_t s;
        s.mudas = 0;
        iniciar_pulso(primeira);
        for (int k = 0; k < N; k++) begin
            servir(k, tab_m[k], tab_d[k], tab_n[k]);
            if (!tab_d[k]) s.mudas += tab_n[k] - 1;
        end
        s.zeras = N; s.v = m_v; s.cls = m_cls;
        swp_q.push_back(s);
        espera(2, "wait_pronto");
        @(negedge clock);
    endtask

    task automatic tabela_random();
        for (int k = 0; k < N; k++) begin
            tab_m[k] = pick();
            tab_d[k] = ($urandom_range(0, 7) == 0);
            tab_n[k] = $urandom_range(1, 3);
        end
    endtask

    // Monitor: pops expectations whenever a new message or pronto appears.
    initial begin
        msg_t e;
        swp_t s;
        int lat_cnt = 0, muda_cnt = 0, zera_cnt = 0;
        logic envia_q = 1'b0, muda_q = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                lat_cnt = 0; muda_cnt = 0; zera_cnt = 0;
                envia_q = 1'b0; muda_q = 1'b0;
            end else begin
                if (mensurar_nvl) lat_cnt = 0; else lat_cnt++;
                if (zera) zera_cnt++;
                if (muda) muda_cnt++;
                if (envia && !envia_q && !muda_q) begin
                    if (msg_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL msg_unexpected: message on canal %0d, required none", canal);
                    end else begin
                        e = msg_q.pop_front();
                        chk("msg_canal", 32'(canal), 32'(e.canal));
                        chk("msg_class", 32'(classificacao), 32'(e.cls));
                        chk("msg_valvulas", 32'(valvulas), 32'(e.v));
                        chk("msg_buzzer_baixa", 32'(buzzer_baixa), 32'(e.bb));
                        chk("msg_buzzer_alta", 32'(buzzer_alta), 32'(e.ba));
                        chk("msg_latency", 32'(lat_cnt), 32'(e.lat));
                    end
                end
                if (pronto) begin
                    if (swp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pronto_unexpected: pronto pulse, required none");
                    end else begin
                        s = swp_q.pop_front();
                        chk("sweep_muda_pulses", 32'(muda_cnt), 32'(s.mudas));
                        chk("sweep_zera_pulses", 32'(zera_cnt), 32'(s.zeras));
                        chk("sweep_valvulas", 32'(valvulas), 32'(s.v));
                        chk("sweep_class", 32'(classificacao), 32'(s.cls));
                        chk("sweep_canal", 32'(canal), 32'd0);
                        chk("sweep_msgs_left", 32'(msg_q.size()), 32'd0);
                    end
                    muda_cnt = 0;
                    zera_cnt = 0;
                end
                envia_q = envia;
                muda_q = muda;
            end
        end
    end

    initial begin
        int m0;
        logic [3:0] v_exp;
        repeat (3) @(negedge clock);
        chk("rst_canal", 32'(canal), 0);
        chk("rst_class", 32'(classificacao), 0);
        chk("rst_valvulas", 32'(valvulas), 0);
        chk("rst_buzzer_baixa", 32'(buzzer_baixa), 0);
        chk("rst_buzzer_alta", 32'(buzzer_alta), 0);
        chk("rst_strobes", {27'd0, zera, mensurar_nvl, envia, muda, pronto}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("idle_no_mensurar", 32'(mensurar_nvl), 0);

        // All tanks normal, single-character messages.
        tab_m = '{1000, 1000, 1000, 1000}; tab_d = '{0, 0, 0, 0}; tab_n = '{1, 1, 1, 1};
        varredura(1'b1);
        chk("s0_valvulas", 32'(valvulas), 0);

        // Tank2 very high opens its valve; tank3 just under low threshold.
        tab_m = '{1000, 1000, 3200, 399}; tab_n = '{1, 3, 1, 1};
        varredura(1'b0);

        // Tank1 discarded; tank2 in hysteresis band; tank3 at low threshold.
        tab_m = '{pick(), 1000, 3100, 400}; tab_d = '{0, 1, 0, 0}; tab_n = '{2, 1, 1, 1};
        varredura(1'b0);

        for (int s = 0; s < 6; s++) begin
            tabela_random();
            varredura(1'b0);
        end

        // Reset while tank0 is settling after a valve move.
        iniciar_pulso(1'b0);
        espera(0, "wait_mensurar_rst");
        m0 = m_v[0] ? 100 : 3500;
        v_exp = m_v;
        v_exp[0] = ~m_v[0];
        medida = 12'(m0);
        fim_medida = 1'b1;
        @(negedge clock);
        fim_medida = 1'b0;
        repeat (3) @(negedge clock);
        chk("espera_valvulas", 32'(valvulas), 32'(v_exp));
        chk("espera_no_envia", 32'(envia), 0);
        reset = 1'b1;
        #1;
        chk("midrst_valvulas", 32'(valvulas), 0);
        chk("midrst_canal", 32'(canal), 0);
        chk("midrst_buzzers", {24'd0, buzzer_baixa, buzzer_alta}, 0);
        chk("midrst_class", 32'(classificacao), 0);
        @(negedge clock);
        chk("midrst_valvulas_edge", 32'(valvulas), 0);
        reset = 1'b0;
        msg_q.delete();
        swp_q.delete();
        m_v = '0; m_bb = '0; m_ba = '0; m_cls = '0;
        @(negedge clock);

        tabela_random();
        varredura(1'b1);

        repeat (5) @(negedge clock);
        chk("end_msgs_pending", 32'(msg_q.size()), 0);
        chk("end_sweeps_pending", 32'(swp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
